// File: rtl/lenet5_pkg.sv
// rtl/lenet5_pkg.sv - shared fixed-point format, layer sizes and FSM state type
package lenet5_pkg;

    localparam int DATA_WIDTH   = 12;
    localparam int FRAC_BITS    = 6;
    localparam int ACC_WIDTH    = 32;
    localparam int N_IN         = 400;
    localparam int N_OUT        = 120;
    localparam int DRAIN_CYCLES = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } fc_state_e;

endpackage

// File: rtl/fc_layer5_if.sv
// rtl/fc_layer5_if.sv - feature/weight/bias read bus and result write bus
interface fc_layer5_if #(
    parameter int DATA_WIDTH = lenet5_pkg::DATA_WIDTH
);

    logic [8:0]            L4_read_addr;
    logic [DATA_WIDTH-1:0] L4_dout;
    logic [15:0]           W_read_addr;
    logic [DATA_WIDTH-1:0] W_dout;
    logic [6:0]            B_read_addr;
    logic [DATA_WIDTH-1:0] B_dout;
    logic [6:0]            L5_write_addr;
    logic                  L5_wea;
    logic [DATA_WIDTH-1:0] L5_din;

    modport master (
        output L4_read_addr, W_read_addr, B_read_addr, L5_write_addr, L5_wea, L5_din,
        input  L4_dout, W_dout, B_dout
    );

    modport slave (
        input  L4_read_addr, W_read_addr, B_read_addr, L5_write_addr, L5_wea, L5_din,
        output L4_dout, W_dout, B_dout
    );

    modport mac (
        input  L4_dout, W_dout, B_dout, L5_wea,
        output L5_din
    );

endinterface

// File: rtl/fc_layer5_mac.sv
// rtl/fc_layer5_mac.sv - fc_mac: product register, accumulator and shift/bias/ReLU/saturate
module fc_mac #(
    parameter int DATA_WIDTH = lenet5_pkg::DATA_WIDTH,
    parameter int FRAC_BITS  = lenet5_pkg::FRAC_BITS,
    parameter int ACC_WIDTH  = lenet5_pkg::ACC_WIDTH
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        issue,
    input  logic        clear,
    fc_layer5_if.mac    bus
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam int SW = ACC_WIDTH + 1;
    localparam logic [SW-1:0] SAT_MAX = SW'((1 << (DATA_WIDTH - 1)) - 1);

    logic                        data_vld;
    logic                        prod_vld;
    logic signed [PW-1:0]        prod;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] acc_shift;
    logic [SW-1:0]               sum;
    logic [DATA_WIDTH-1:0]       result;

    // Memory data arrives one cycle after issue; product and accumulate follow one cycle each.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_vld <= 1'b0;
            prod_vld <= 1'b0;
            prod     <= '0;
            acc      <= '0;
        end else begin
            data_vld <= issue;
            prod_vld <= data_vld;
            if (data_vld) begin
                prod <= $signed(bus.L4_dout) * $signed(bus.W_dout);
            end
            if (clear) begin
                acc <= '0;
            end else if (prod_vld) begin
                acc <= acc + {{(ACC_WIDTH - PW){prod[PW-1]}}, prod};
            end
        end
    end

    assign acc_shift = acc >>> FRAC_BITS;
    assign sum = {acc_shift[ACC_WIDTH-1], acc_shift}
               + {{(SW - DATA_WIDTH){bus.B_dout[DATA_WIDTH-1]}}, bus.B_dout};

    always_comb begin
        result = sum[DATA_WIDTH-1:0];
        if (sum[SW-1]) begin
            result = '0;
        end else if (sum > SAT_MAX) begin
            result = SAT_MAX[DATA_WIDTH-1:0];
        end
    end

    assign bus.L5_din = bus.L5_wea ? result : '0;

endmodule

// File: rtl/fc_layer5.sv
// rtl/fc_layer5.sv - fully connected layer controller: streams features x weights per neuron
module fc_layer5 #(
    parameter int DATA_WIDTH = lenet5_pkg::DATA_WIDTH,
    parameter int FRAC_BITS  = lenet5_pkg::FRAC_BITS,
    parameter int N_IN       = lenet5_pkg::N_IN,
    parameter int N_OUT      = lenet5_pkg::N_OUT,
    parameter int ACC_WIDTH  = lenet5_pkg::ACC_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [8:0]            L4_read_addr,
    input  logic [DATA_WIDTH-1:0] L4_dout,
    output logic [15:0]           W_read_addr,
    input  logic [DATA_WIDTH-1:0] W_dout,
    output logic [6:0]            B_read_addr,
    input  logic [DATA_WIDTH-1:0] B_dout,
    output logic [6:0]            L5_write_addr,
    output logic                  L5_wea,
    output logic [DATA_WIDTH-1:0] L5_din,
    output logic                  busy,
    output logic                  done
);

    import lenet5_pkg::*;

    localparam logic [8:0] IDX_LAST    = 9'(N_IN - 1);
    localparam logic [6:0] NEURON_LAST = 7'(N_OUT - 1);
    localparam logic [1:0] DRAIN_LAST  = 2'(DRAIN_CYCLES - 1);

    fc_state_e   state, state_nxt;
    logic [8:0]  idx;
    logic [15:0] w_addr;
    logic [6:0]  neuron;
    logic [1:0]  dcnt;
    logic        issue;
    logic        acc_clear;

    fc_layer5_if #(.DATA_WIDTH(DATA_WIDTH)) mem_bus ();

    // w_addr runs continuously across neurons, so it tracks neuron*N_IN+idx without a multiplier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            idx    <= '0;
            w_addr <= '0;
            neuron <= '0;
            dcnt   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        idx    <= '0;
                        w_addr <= '0;
                        neuron <= '0;
                        dcnt   <= '0;
                    end
                end
                S_ISSUE: begin
                    w_addr <= w_addr + 16'd1;
                    dcnt   <= '0;
                    idx    <= (idx == IDX_LAST) ? 9'd0 : idx + 9'd1;
                end
                S_DRAIN: dcnt <= dcnt + 2'd1;
                S_WRITE: begin
                    if (neuron != NEURON_LAST) begin
                        neuron <= neuron + 7'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_ISSUE;
            S_ISSUE: if (idx == IDX_LAST) state_nxt = S_DRAIN;
            S_DRAIN: if (dcnt == DRAIN_LAST) state_nxt = S_WRITE;
            S_WRITE: state_nxt = (neuron == NEURON_LAST) ? S_DONE : S_ISSUE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign issue     = (state == S_ISSUE);
    assign acc_clear = issue && (idx == 9'd0);
    assign busy      = (state == S_ISSUE) || (state == S_DRAIN) || (state == S_WRITE);
    assign done      = (state == S_DONE);

    assign mem_bus.L4_dout       = L4_dout;
    assign mem_bus.W_dout        = W_dout;
    assign mem_bus.B_dout        = B_dout;
    assign mem_bus.L4_read_addr  = idx;
    assign mem_bus.W_read_addr   = w_addr;
    assign mem_bus.B_read_addr   = neuron;
    assign mem_bus.L5_write_addr = neuron;
    assign mem_bus.L5_wea        = (state == S_WRITE);

    assign L4_read_addr  = mem_bus.L4_read_addr;
    assign W_read_addr   = mem_bus.W_read_addr;
    assign B_read_addr   = mem_bus.B_read_addr;
    assign L5_write_addr = mem_bus.L5_write_addr;
    assign L5_wea        = mem_bus.L5_wea;
    assign L5_din        = mem_bus.L5_din;

    fc_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_BITS  (FRAC_BITS),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .issue (issue),
        .clear (acc_clear),
        .bus   (mem_bus)
    );

endmodule

// File: doc/fc_layer5.md
FC_LAYER5 -- requirements
Module: fc_layer5

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, default 12, feature/weight/bias/output width (signed two's complement).
REQ-002 SHALL have parameters: FRAC_BITS, default 6, fractional bits of the fixed-point format.
REQ-003 SHALL have parameters: N_IN, default 400, pooled features per neuron (16 ch x 5 x 5).
REQ-004 SHALL have parameters: N_OUT, default 120, output neurons.
REQ-005 SHALL have parameters: ACC_WIDTH, default 32, accumulator width.
REQ-006 SHALL have ports:
  clk  in  1  rising-edge clock.
  rst_n  in  1  asynchronous active-low reset.
  start  in  1  one-cycle pulse; upstream pool_done.
  L4_read_addr  out  9  feature memory address.
  L4_dout  in  DATA_WIDTH  feature data, valid one cycle after address.
  W_read_addr  out  16  weight ROM address.
  W_dout  in  DATA_WIDTH  weight data, 1-cycle latency.
  B_read_addr  out  7  bias ROM address.
  B_dout  in  DATA_WIDTH  bias data, 1-cycle latency.
  L5_write_addr  out  7  result memory address.
  L5_wea  out  1  result write enable.
  L5_din  out  DATA_WIDTH  result data.
  busy  out  1  high from start acceptance to done.
  done  out  1  one-cycle completion pulse.

Function
REQ-007 SHALL implement FSM IDLE -> ISSUE -> DRAIN -> WRITE -> (ISSUE next neuron | DONE) -> IDLE.
REQ-008 SHALL leave IDLE only on start=1; start while busy SHALL be ignored.
REQ-009 ISSUE SHALL last N_IN cycles per neuron, presenting idx 0..N_IN-1 on L4_read_addr.
REQ-010 W_read_addr SHALL equal neuron*N_IN+idx, produced by a running counter, no multiplier.
REQ-011 B_read_addr SHALL equal the current neuron index throughout that neuron.
REQ-012 Pipeline SHALL be: address (t), memory data (t+1), registered product (t+2), accumulate (t+3).
REQ-013 DRAIN SHALL last 3 cycles, so the accumulator holds all N_IN products on WRITE entry.
REQ-014 Accumulator SHALL clear at the first ISSUE cycle of each neuron.
REQ-015 Products SHALL be full 2*DATA_WIDTH signed, sign-extended to ACC_WIDTH.
REQ-016 Result SHALL be (acc >>> FRAC_BITS) + sign-extended bias.
REQ-017 Result SHALL then pass through ReLU: negative -> 0.
REQ-018 Result SHALL saturate: values > 2^(DATA_WIDTH-1)-1 clamp to that maximum.
REQ-019 WRITE SHALL last one cycle: L5_wea=1, L5_write_addr=neuron, L5_din=result.
REQ-020 Per-neuron cost SHALL be N_IN+4 cycles.
REQ-021 done SHALL pulse one cycle after the last neuron's WRITE, at cycle N_OUT*(N_IN+4)+1 after the start cycle.
REQ-022 busy SHALL fall in the same cycle done pulses.
REQ-023 Exactly N_OUT writes SHALL occur per run.
REQ-024 Outside WRITE, L5_wea SHALL be 0.

Reset
REQ-025 rst_n low SHALL immediately force IDLE and clear counters and accumulator.
REQ-026 rst_n low SHALL clear all outputs to 0 (addresses, L5_wea, L5_din, busy, done).
REQ-027 Reset mid-run SHALL abort with no further writes and no done; a later start SHALL run from neuron 0.

Structure
REQ-028 Package lenet5_pkg SHALL hold the format constants DATA_WIDTH and FRAC_BITS.
REQ-029 Package lenet5_pkg SHALL hold the layer-size constants N_IN, N_OUT and the FSM state enum.
REQ-030 Sub-module fc_mac SHALL contain the product register, accumulator, and shift/bias/ReLU/saturate logic.

Verification
REQ-031 All features 64, all weights 1, bias 0 -> 120 writes of 400, addresses 0..119; done at cycle 48481.
REQ-032 Weights -1, features 64, bias 0 -> all L5_din = 0 (ReLU).
REQ-033 Features 64, weights 64, bias 0 -> all L5_din = 2047 (saturation).
REQ-034 Features 0, bias[n] = n -> L5_din[n] = n.
REQ-035 Second start pulse at cycle 1000 -> ignored; still exactly 120 writes and one done.
REQ-036 rst_n low one cycle during neuron 50 -> outputs 0, no done.
REQ-037 After the REQ-036 abort, a new start -> full 120-write run from address 0.
